// File: rtl/debug_frame_sender_if.sv
// Byte stream handshake between the debug frame sender and the UART transmitter.
// The master drives data/valid, the slave answers with ready.
interface debug_frame_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/debug_frame_sender.sv
// Snapshots pipeline debug state on a trigger and streams it as a byte frame over a valid/ready link.
// Optional `DBG_CHECKSUM_EN appends an XOR checksum byte (190-byte frame instead of 189).
module debug_frame_sender #(
  parameter logic [7:0] HEADER_BYTE  = 8'hA5,
  parameter bit         AUTO_ON_HALT = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1023:0]               du_reg,
  input  logic [255:0]                du_mem,
  input  logic [63:0]                 du_if_id,
  input  logic [125:0]                du_id_ex,
  input  logic                        du_halt,
  input  logic                        dump_req,
  debug_frame_sender_if.master        tx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [31:0]                 cycle_count
);

  // Payload after the header: cycle count, registers, memory, IF/ID, zero-extended ID/EX.
  localparam int SNAP_W = 32 + 1024 + 256 + 64 + 128;

`ifdef DBG_CHECKSUM_EN
  localparam logic [7:0] LAST_IDX = 8'd189;
`else
  localparam logic [7:0] LAST_IDX = 8'd188;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [SNAP_W-1:0]   shadow_r;
  logic [7:0]          byte_idx_r;
  logic [7:0]          tx_data_r;
  logic                tx_valid_r;
  logic                busy_r;
  logic                frame_done_r;
  logic [31:0]         cycle_count_r;
  logic                halt_q_r;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]          csum_r;
`endif

  logic                trig_s;
  logic                load_s;
  logic                xfer_s;

  assign trig_s = dump_req | (AUTO_ON_HALT & du_halt & ~halt_q_r);
  assign load_s = (state_r == ST_IDLE) & trig_s;
  assign xfer_s = tx_valid_r & tx.tx_ready;

  assign tx.tx_data  = tx_data_r;
  assign tx.tx_valid = tx_valid_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign cycle_count = cycle_count_r;

  // Free-running saturating cycle counter (frozen while halted) and halt edge register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count_r <= 32'd0;
      halt_q_r      <= 1'b0;
    end else begin
      halt_q_r <= du_halt;
      if (!du_halt && (cycle_count_r != 32'hFFFF_FFFF)) begin
        cycle_count_r <= cycle_count_r + 32'd1;
      end
    end
  end

  // Snapshot shadow: loaded on a trigger, shifted one byte per transfer; deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_s) begin
      shadow_r <= {cycle_count_r, du_reg, du_mem, du_if_id, 2'b00, du_id_ex};
    end else if ((state_r == ST_SEND) && xfer_s) begin
      shadow_r <= {shadow_r[SNAP_W-9:0], 8'h00};
    end
  end

  // Frame sequencer: registered handshake, busy and done outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      tx_valid_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      byte_idx_r   <= 8'd0;
`ifdef DBG_CHECKSUM_EN
      csum_r       <= 8'h00;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          frame_done_r <= 1'b0;
          if (trig_s) begin
            state_r    <= ST_SEND;
            tx_valid_r <= 1'b1;
            tx_data_r  <= HEADER_BYTE;
            busy_r     <= 1'b1;
            byte_idx_r <= 8'd0;
`ifdef DBG_CHECKSUM_EN
            csum_r     <= 8'h00;
`endif
          end
        end
        ST_SEND: begin
          if (xfer_s) begin
`ifdef DBG_CHECKSUM_EN
            csum_r <= csum_r ^ tx_data_r;
`endif
            if (byte_idx_r == LAST_IDX) begin
              state_r      <= ST_DONE;
              tx_valid_r   <= 1'b0;
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
            end else begin
              byte_idx_r <= byte_idx_r + 8'd1;
`ifdef DBG_CHECKSUM_EN
              // The checksum byte folds in the byte being accepted right now.
              if (byte_idx_r == (LAST_IDX - 8'd1)) begin
                tx_data_r <= csum_r ^ tx_data_r;
              end else begin
                tx_data_r <= shadow_r[SNAP_W-1 -: 8];
              end
`else
              tx_data_r <= shadow_r[SNAP_W-1 -: 8];
`endif
            end
          end
        end
        ST_DONE: begin
          frame_done_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          tx_valid_r   <= 1'b0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_sender.sv
// Self-checking bench for debug_frame_sender: table-driven frames, hand-written corner sequences
// and randomized frames, all compared against a byte-level frame model built from field rules.
module tb_debug_frame_sender;

`ifdef DBG_CHECKSUM_EN
  localparam int FRAME_LEN = 190;
`else
  localparam int FRAME_LEN = 189;
`endif

  logic          clk;
  logic          reset;
  logic [1023:0] du_reg;
  logic [255:0]  du_mem;
  logic [63:0]   du_if_id;
  logic [125:0]  du_id_ex;
  logic          du_halt;
  logic          dump_req;
  logic          busy;
  logic          frame_done;
  logic [31:0]   cycle_count;

  debug_frame_sender_if bus();

  debug_frame_sender #(.HEADER_BYTE(8'hA5), .AUTO_ON_HALT(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .du_reg      (du_reg),
    .du_mem      (du_mem),
    .du_if_id    (du_if_id),
    .du_id_ex    (du_id_ex),
    .du_halt     (du_halt),
    .dump_req    (dump_req),
    .tx          (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] model_cc = 32'd0;
  int          done_cnt = 0;
  int          stall_err = 0;

  typedef struct {
    logic [31:0] cc;
    logic [31:0] r31;
    int          mode;
    logic [71:0] head;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: record transfers, then update the reference cycle counter from applied inputs.
  task automatic step();
    logic [7:0] held;
    logic       stalled;
    stalled = bus.tx_valid && !bus.tx_ready;
    held    = bus.tx_data;
    if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
    @(posedge clk);
    if (!reset) model_cc = 32'd0;
    else if (!du_halt && model_cc != 32'hFFFF_FFFF) model_cc = model_cc + 32'd1;
    #1;
    if (stalled && reset && (!bus.tx_valid || bus.tx_data !== held)) stall_err++;
    if (frame_done) done_cnt++;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 32; i++) du_reg[i*32 +: 32] = $urandom;
    for (int i = 0; i < 8; i++) du_mem[i*32 +: 32] = $urandom;
    du_if_id = {$urandom, $urandom};
    du_id_ex = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference frame built field by field, each field most-significant byte first.
  task automatic build_expected(input logic [31:0] cc);
    logic [127:0] ext;
    logic [7:0]   x;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int b = 3; b >= 0; b--) exp_q.push_back(cc[b*8 +: 8]);
    for (int r = 31; r >= 0; r--)
      for (int b = 3; b >= 0; b--) exp_q.push_back(du_reg[r*32 + b*8 +: 8]);
    for (int b = 31; b >= 0; b--) exp_q.push_back(du_mem[b*8 +: 8]);
    for (int b = 7; b >= 0; b--) exp_q.push_back(du_if_id[b*8 +: 8]);
    ext = {2'b00, du_id_ex};
    for (int b = 15; b >= 0; b--) exp_q.push_back(ext[b*8 +: 8]);
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
`ifdef DBG_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic compare_frame(input string name);
    int bad;
    bad = 0;
    check({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    check({name, "_bad_bytes"}, bad, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0; dump_req = 1'b0; du_halt = 1'b0; bus.tx_ready = 1'b1;
    step(); step();
    reset = 1'b1;
  endtask

  // Caller has set dump_req=1; runs one frame under the given ready pattern and checks it.
  task automatic send_frame(input string name, input int mode, input bit noisy);
    int cycles;
    rx_q.delete(); done_cnt = 0; stall_err = 0;
    build_expected(model_cc);
    step();
    dump_req = 1'b0;
    check({name, "_start_valid"}, bus.tx_valid, 1'b1);
    check({name, "_start_hdr"}, bus.tx_data, 8'hA5);
    check({name, "_start_busy"}, busy, 1'b1);
    if (noisy) rand_inputs();
    cycles = 0;
    while (done_cnt == 0 && cycles < 3000) begin
      case (mode)
        0: bus.tx_ready = 1'b1;
        1: bus.tx_ready = ((cycles % 4) == 0) || ((cycles % 4) == 3);
        default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (!bus.tx_valid) stall_err++;
      dump_req = noisy && rx_q.size() > 0 && rx_q.size() < FRAME_LEN && ($urandom_range(0, 15) == 0);
      step();
      cycles++;
    end
    dump_req = 1'b0;
    check({name, "_done_once"}, done_cnt, 1);
    check({name, "_done_valid"}, bus.tx_valid, 1'b0);
    check({name, "_done_busy"}, busy, 1'b0);
    check({name, "_handshake_err"}, stall_err, 0);
    if (mode == 0) check({name, "_cycles"}, cycles, FRAME_LEN);
    compare_frame(name);
    bus.tx_ready = 1'b1;
    step();
    check({name, "_done_pulse"}, frame_done, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check({name, "_no_refire"}, bus.tx_valid, 1'b0);
  endtask

  initial begin
    logic [71:0] head;
    logic [31:0] halt_cc;
    int guard;

    reset = 1'b0; dump_req = 1'b0; du_halt = 1'b0; bus.tx_ready = 1'b1;
    du_reg = '0; du_mem = '0; du_if_id = '0; du_id_ex = '0;

    tbl[0] = '{32'h0000_002A, 32'hDEAD_BEEF, 0, 72'hA5_0000002A_DEADBEEF};
    tbl[1] = '{32'h0000_0005, 32'h0123_4567, 1, 72'hA5_00000005_01234567};
    tbl[2] = '{32'h0000_00C8, 32'h0000_0000, 2, 72'hA5_000000C8_00000000};
    tbl[3] = '{32'h0000_0001, 32'hFFFF_FFFF, 1, 72'hA5_00000001_FFFFFFFF};

    // Reset state, then 10 idle cycles.
    step(); step();
    check("rst_valid", bus.tx_valid, 1'b0);
    check("rst_data", bus.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_cc", cycle_count, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("idle10_cc", cycle_count, 32'd10);
    check("idle10_valid", bus.tx_valid, 1'b0);
    check("idle10_busy", busy, 1'b0);

`ifdef DBG_CHECKSUM_EN
    // All-zero snapshot at cycle 0: checksum equals the header.
    reset = 1'b0; step();
    reset = 1'b1; dump_req = 1'b1;
    send_frame("csum", 0, 1'b0);
    check("csum_len", rx_q.size(), 190);
    check("csum_last", (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'h00, 8'hA5);
`endif

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      rand_inputs();
      du_reg[1023:992] = tbl[v].r31;
      guard = 0;
      while (model_cc != tbl[v].cc && guard < 1000) begin step(); guard++; end
      check($sformatf("vec%0d_cc", v), cycle_count, model_cc);
      dump_req = 1'b1;
      send_frame($sformatf("vec%0d", v), tbl[v].mode, 1'b0);
      head = '0;
      for (int i = 0; i < 9; i++) head = {head[63:0], (i < rx_q.size()) ? rx_q[i] : 8'h00};
      check($sformatf("vec%0d_head", v), head, tbl[v].head);
    end

    // Reset at byte 50 abandons the frame.
    do_reset();
    rand_inputs();
    for (int i = 0; i < 7; i++) step();
    dump_req = 1'b1; rx_q.delete(); step(); dump_req = 1'b0;
    guard = 0;
    while (rx_q.size() < 50 && guard < 500) begin step(); guard++; end
    check("midrst_reached", rx_q.size(), 50);
    reset = 1'b0; step();
    check("midrst_valid", bus.tx_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cc", cycle_count, 32'd0);
    reset = 1'b1; rx_q.delete();
    for (int i = 0; i < 3; i++) step();
    check("midrst_after_valid", bus.tx_valid, 1'b0);
    check("midrst_after_cc", cycle_count, model_cc);
    check("midrst_no_bytes", rx_q.size(), 0);

    // Halt held high for 500 cycles: one frame, count frozen at the pre-halt value.
    do_reset();
    rand_inputs();
    for (int i = 0; i < 30; i++) step();
    halt_cc = model_cc;
    build_expected(model_cc);
    rx_q.delete(); done_cnt = 0;
    du_halt = 1'b1;
    for (int i = 0; i < 500; i++) step();
    check("halt_frames", done_cnt, 1);
    compare_frame("halt");
    check("halt_cc_held", cycle_count, halt_cc);
    du_halt = 1'b0; step(); step();

    // dump_req coincident with the halt edge: one frame.
    rand_inputs();
    build_expected(model_cc);
    rx_q.delete(); done_cnt = 0;
    dump_req = 1'b1; du_halt = 1'b1; step(); dump_req = 1'b0;
    for (int i = 0; i < 600; i++) step();
    check("collide_frames", done_cnt, 1);
    compare_frame("collide");
    du_halt = 1'b0; step();

    // Retrigger at byte 100 and in the DONE cycle: both dropped.
    rand_inputs();
    build_expected(model_cc);
    rx_q.delete(); done_cnt = 0;
    dump_req = 1'b1; step(); dump_req = 1'b0;
    guard = 0;
    while (rx_q.size() < 100 && guard < 500) begin step(); guard++; end
    dump_req = 1'b1; step(); dump_req = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 500) begin step(); guard++; end
    dump_req = 1'b1; step(); dump_req = 1'b0;
    for (int i = 0; i < 300; i++) step();
    check("retrig_frames", done_cnt, 1);
    compare_frame("retrig");

    // Randomized frames: random inputs, idle gaps, ready, inputs changing mid-frame, stray requests.
    for (int k = 0; k < 4; k++) begin
      rand_inputs();
      guard = $urandom_range(0, 20);
      for (int i = 0; i < guard; i++) step();
      dump_req = 1'b1;
      send_frame($sformatf("rand%0d", k), 2, 1'b1);
      check($sformatf("rand%0d_cc", k), cycle_count, model_cc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_frame_sender.md
Name: debug_frame_sender

Overview:
- Downstream consumer of the pipeline datapath debug outputs: register file (du_reg), data memory (du_mem), IF/ID latch (du_if_id), ID/EX latch (du_id_ex) and the WB-stage halt flag (du_halt).
- On a trigger it snapshots all debug state plus a free-running cycle count into one shadow register.
- It then streams the snapshot as a fixed byte frame over a valid/ready byte interface to the UART transmitter of the debug unit.

Parameters:
- HEADER_BYTE, 8'hA5, first byte of every frame.
- AUTO_ON_HALT, 1, when 1 a rising edge of du_halt triggers a dump; when 0 only dump_req triggers.

Ports:
- clk  in  1  system clock, same clock as the datapath.
- reset  in  1  synchronous, active-low reset.
- du_reg  in  1024  register file image; register 31 in bits [1023:992], register 0 in [31:0].
- du_mem  in  256  data memory image.
- du_if_id  in  64  {instruction, PC+4}.
- du_id_ex  in  126  ID/EX latch image.
- du_halt  in  1  halt flag from the WB stage.
- dump_req  in  1  single-cycle dump request from the command decoder.
- tx_ready  in  1  UART TX can accept a byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid.
- busy  out  1  a frame is being captured or sent.
- frame_done  out  1  one-cycle pulse after the last byte is accepted.
- cycle_count  out  32  live cycle counter.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, tx_valid=0, tx_data=0, busy=0, frame_done=0, cycle_count=0, byte index=0, halt edge register=0. The shadow register is not reset.
- Cycle counter:
  - Increments by 1 every clk while du_halt==0.
  - Holds while du_halt==1.
  - Saturates at 32'hFFFFFFFF; no wrap.
- Trigger:
  - trig = dump_req | (AUTO_ON_HALT & du_halt & ~halt_q), where halt_q is du_halt delayed one cycle.
  - If dump_req and a halt edge occur in the same cycle, exactly one frame is produced.
  - A trigger while busy==1 is dropped, not queued.
  - A du_halt held high produces only one frame.
- IDLE:
  - On trig at edge N, the snapshot latches {cycle_count, du_reg, du_mem, du_if_id, 2'b00, du_id_ex}.
  - The snapshot uses the values present before edge N; the cycle count is the pre-increment value.
  - busy=1, state goes to SEND, tx_valid=1 and tx_data=HEADER_BYTE from cycle N+1.
- SEND:
  - A byte is transferred on any clk where tx_valid & tx_ready.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops mid-frame.
  - After each transfer the next byte is presented in the following cycle. Throughput is one byte per cycle if tx_ready stays high.
- Frame byte order, with each field sent most-significant byte first:
  - header (1 byte)
  - cycle_count (4 bytes)
  - du_reg (128 bytes, starting with register 31 bits [31:24])
  - du_mem (32 bytes)
  - du_if_id (8 bytes)
  - du_id_ex zero-extended to 128 bits (16 bytes)
  - Total: 189 bytes.
- DONE:
  - Entered after the last transfer.
  - For one cycle: tx_valid=0, frame_done=1, busy=0.
  - Then returns to IDLE.
  - A trigger arriving in the DONE cycle is dropped.
- Byte index is 8 bits and never exceeds the last index; there is no wrap.
- If reset is asserted mid-frame, the frame is abandoned immediately. tx_valid=0 on the cycle after the reset edge, and no partial-frame continuation occurs.

Optional Feature:
- DBG_CHECKSUM_EN defined: one extra byte follows the id_ex field. It is the XOR of all preceding frame bytes, header included. The frame is 190 bytes and frame_done pulses after the checksum byte is accepted.
- DBG_CHECKSUM_EN undefined: the frame is 189 bytes, no checksum logic is present, and timing is otherwise identical.

Test Plan:
- Reset checks:
  - Release reset with tx_ready=1 and du_halt=0, then 10 idle cycles -> cycle_count=10, tx_valid=0, busy=0.
  - Separately, assert reset at byte 50 with tx_ready=1 -> next cycle tx_valid=0 and busy=0, and cycle_count restarts from 0.
- Basic dump, dump_req pulse:
  - Setup: dump_req at cycle_count=0x0000002A, du_reg register 31=0xDEADBEEF, tx_ready=1.
  - Required bytes: A5,00,00,00,2A,DE,AD,BE,EF...
  - 189 transfers in 189 consecutive cycles, then frame_done pulses once.
- Backpressure:
  - Toggle tx_ready 1,0,0,1 repeatedly.
  - tx_data stays stable while ready=0, no byte is duplicated or skipped, and the received frame equals the no-backpressure frame.
- Halt trigger (AUTO_ON_HALT=1): du_halt rises and stays high for 500 cycles -> exactly one frame, and the cycle_count field equals the count before the halt.
- Collision and retrigger:
  - dump_req and the halt edge in the same cycle -> one frame only.
  - dump_req during byte 100 -> ignored, and no second frame follows.
- Checksum: with DBG_CHECKSUM_EN and all inputs zero at cycle_count=0 -> 190 bytes, the last byte is 0xA5.
